hdmi_gearbox: RTL and testbench

// - Parametrised MSB-first width gearbox: packs IN_WIDTH-bit pixel words into OUT_WIDTH-bit FIFO words.
// - Sits between the TFP401 HDMI receiver RGB bus and the frame FIFO; successor of the fixed 24->32 packer.
// - Adds frame/line re-alignment with zero-padded flush, a first-word marker, and overflow detection.

---
 rtl/hdmi_gearbox.sv | 123 ++++++++++++
 tb/tb_hdmi_gearbox.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hdmi_gearbox.sv
// MSB-first width gearbox: packs IN_WIDTH-bit pixels into OUT_WIDTH-bit FIFO words,
// with sync-triggered zero-padded flush, first-word marking and dropped-word accounting.
module hdmi_gearbox #(
    parameter int IN_WIDTH       = 24,
    parameter int OUT_WIDTH      = 32,
    parameter int FLUSH_MODE     = 1,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [IN_WIDTH-1:0]       i_hdmiData,
    input  logic                      i_dataValid,
    input  logic                      i_hSync,
    input  logic                      i_vSync,
    input  logic                      i_fifoFull,
    output logic [OUT_WIDTH-1:0]      o_fifoData,
    output logic                      o_dataValid,
    output logic                      o_firstWord,
    output logic                      o_overflow,
    output logic [DROP_CNT_WIDTH-1:0] o_dropCount
);

    localparam int ACC_W  = OUT_WIDTH + IN_WIDTH - 1;
    localparam int FILL_W = $clog2(OUT_WIDTH + IN_WIDTH);

    logic [ACC_W-1:0]     r_acc;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_vsync_d;
    logic                 r_hsync_d;
    logic                 r_first;

    logic [ACC_W-1:0]     w_pix_ext;
    logic [ACC_W-1:0]     w_merged;
    logic [FILL_W-1:0]    w_sum;
    logic                 w_full_word;
    logic                 w_edge;
    logic                 w_done;
    logic                 w_is_data;
    logic [OUT_WIDTH-1:0] w_word;

    // Bits below r_fill in r_acc are always zero, so a plain OR appends the pixel.
    assign w_pix_ext   = {i_hdmiData, {(OUT_WIDTH-1){1'b0}}};
    assign w_merged    = r_acc | (w_pix_ext >> r_fill);
    assign w_sum       = r_fill + FILL_W'(IN_WIDTH);
    assign w_full_word = (w_sum >= FILL_W'(OUT_WIDTH));

    always_comb begin
        w_edge = 1'b0;
        if (FLUSH_MODE != 0 && i_vSync && !r_vsync_d)
            w_edge = 1'b1;
        if (FLUSH_MODE == 2 && i_hSync && !r_hsync_d)
            w_edge = 1'b1;
    end

    always_comb begin
        w_done    = 1'b0;
        w_is_data = 1'b0;
        w_word    = r_acc[ACC_W-1 -: OUT_WIDTH];
        if (w_edge) begin
            w_done = (r_fill != '0);
        end else if (i_dataValid && w_full_word) begin
            w_done    = 1'b1;
            w_is_data = 1'b1;
            w_word    = w_merged[ACC_W-1 -: OUT_WIDTH];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_acc       <= '0;
            r_fill      <= '0;
            r_vsync_d   <= 1'b0;
            r_hsync_d   <= 1'b0;
            r_first     <= 1'b0;
            o_fifoData  <= '0;
            o_dataValid <= 1'b0;
            o_firstWord <= 1'b0;
            o_overflow  <= 1'b0;
            o_dropCount <= '0;
        end else begin
            r_vsync_d   <= i_vSync;
            r_hsync_d   <= i_hSync;
            o_dataValid <= 1'b0;
            o_firstWord <= 1'b0;

            // The pixel on an edge cycle starts the new alignment after the flush.
            if (w_edge) begin
                r_first <= 1'b1;
                if (i_dataValid) begin
                    r_acc  <= w_pix_ext;
                    r_fill <= FILL_W'(IN_WIDTH);
                end else begin
                    r_acc  <= '0;
                    r_fill <= '0;
                end
            end else if (i_dataValid) begin
                if (w_full_word) begin
                    r_acc  <= w_merged << OUT_WIDTH;
                    r_fill <= w_sum - FILL_W'(OUT_WIDTH);
                end else begin
                    r_acc  <= w_merged;
                    r_fill <= w_sum;
                end
            end

            // A dropped word still advances the accumulator and consumes the first-word flag.
            if (w_done) begin
                if (w_is_data)
                    r_first <= 1'b0;
                if (i_fifoFull) begin
                    o_overflow <= 1'b1;
                    if (o_dropCount != {DROP_CNT_WIDTH{1'b1}})
                        o_dropCount <= o_dropCount + 1'b1;
                end else begin
                    o_dataValid <= 1'b1;
                    o_fifoData  <= w_word;
                    o_firstWord <= w_is_data && r_first;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_gearbox.sv
// Table-driven bench for hdmi_gearbox: default 24->32 instance plus a 16->24 hSync-flush instance.
module tb_hdmi_gearbox;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 24 -> 32, vSync realign
    logic [23:0] d1;
    logic        v1, hs1, vs1, full1;
    logic [31:0] o_data1;
    logic        o_dv1, o_first1, o_ovf1;
    logic [15:0] o_drop1;

    // 16 -> 24, vSync or hSync realign
    logic [15:0] d2;
    logic        v2, hs2, vs2, full2;
    logic [23:0] o_data2;
    logic        o_dv2, o_first2, o_ovf2;
    logic [15:0] o_drop2;

    hdmi_gearbox u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_hdmiData(d1), .i_dataValid(v1),
        .i_hSync(hs1), .i_vSync(vs1), .i_fifoFull(full1),
        .o_fifoData(o_data1), .o_dataValid(o_dv1), .o_firstWord(o_first1),
        .o_overflow(o_ovf1), .o_dropCount(o_drop1)
    );

    hdmi_gearbox #(.IN_WIDTH(16), .OUT_WIDTH(24), .FLUSH_MODE(2), .DROP_CNT_WIDTH(16)) u_dut2 (
        .i_clock(clk), .i_reset(rst), .i_hdmiData(d2), .i_dataValid(v2),
        .i_hSync(hs2), .i_vSync(vs2), .i_fifoFull(full2),
        .o_fifoData(o_data2), .o_dataValid(o_dv2), .o_firstWord(o_first2),
        .o_overflow(o_ovf2), .o_dropCount(o_drop2)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        vs;
        logic        hs;
        logic        full;
        logic        edv;
        logic [31:0] ed;
        logic        ef;
        logic        eovf;
        logic [15:0] edrop;
    } vec_t;

    vec_t tbl1[26];
    vec_t tbl2[6];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic v, logic [31:0] d, logic vs, logic hs, logic full,
                                logic edv, logic [31:0] ed, logic ef, logic eovf, logic [15:0] edrop);
        vec_t r;
        r.v = v; r.d = d; r.vs = vs; r.hs = hs; r.full = full;
        r.edv = edv; r.ed = ed; r.ef = ef; r.eovf = eovf; r.edrop = edrop;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run1(int i);
        @(negedge clk);
        d1 = tbl1[i].d[23:0]; v1 = tbl1[i].v; vs1 = tbl1[i].vs; hs1 = tbl1[i].hs; full1 = tbl1[i].full;
        @(posedge clk); #1;
        chk($sformatf("dut1 row%0d dv", i),    32'(o_dv1),    32'(tbl1[i].edv));
        chk($sformatf("dut1 row%0d data", i),  o_data1,       tbl1[i].ed);
        chk($sformatf("dut1 row%0d first", i), 32'(o_first1), 32'(tbl1[i].ef));
        chk($sformatf("dut1 row%0d ovf", i),   32'(o_ovf1),   32'(tbl1[i].eovf));
        chk($sformatf("dut1 row%0d drop", i),  32'(o_drop1),  32'(tbl1[i].edrop));
        $display("dut1 row%0d: in=%h v=%b vs=%b full=%b -> dv=%b data=%h first=%b ovf=%b drop=%0d",
                 i, d1, v1, vs1, full1, o_dv1, o_data1, o_first1, o_ovf1, o_drop1);
    endtask

    task automatic run2(int i);
        @(negedge clk);
        d2 = tbl2[i].d[15:0]; v2 = tbl2[i].v; vs2 = tbl2[i].vs; hs2 = tbl2[i].hs; full2 = tbl2[i].full;
        @(posedge clk); #1;
        chk($sformatf("dut2 row%0d dv", i),    32'(o_dv2),    32'(tbl2[i].edv));
        chk($sformatf("dut2 row%0d data", i),  32'(o_data2),  tbl2[i].ed);
        chk($sformatf("dut2 row%0d first", i), 32'(o_first2), 32'(tbl2[i].ef));
        chk($sformatf("dut2 row%0d ovf", i),   32'(o_ovf2),   32'(tbl2[i].eovf));
        $display("dut2 row%0d: in=%h v=%b hs=%b -> dv=%b data=%h first=%b",
                 i, d2, v2, hs2, o_dv2, o_data2, o_first2);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " dv1"},    32'(o_dv1),    32'd0);
        chk({tag, " data1"},  o_data1,       32'd0);
        chk({tag, " first1"}, 32'(o_first1), 32'd0);
        chk({tag, " ovf1"},   32'(o_ovf1),   32'd0);
        chk({tag, " drop1"},  32'(o_drop1),  32'd0);
        chk({tag, " dv2"},    32'(o_dv2),    32'd0);
        chk({tag, " data2"},  32'(o_data2),  32'd0);
        $display("%s: dut1 dv=%b data=%h ovf=%b drop=%0d; dut2 dv=%b data=%h",
                 tag, o_dv1, o_data1, o_ovf1, o_drop1, o_dv2, o_data2);
    endtask

    initial begin
        //                  v  d             vs hs fl  edv ed            ef ovf drop
        // defaults: vSync edge, then four pixels
        tbl1[0]  = mk(0, 32'h0,        1, 0, 0,  0, 32'h0,        0, 0, 0);
        tbl1[1]  = mk(1, 32'h112233,   1, 0, 0,  0, 32'h0,        0, 0, 0);
        tbl1[2]  = mk(1, 32'h445566,   1, 0, 0,  1, 32'h11223344, 1, 0, 0);
        tbl1[3]  = mk(1, 32'h778899,   1, 0, 0,  1, 32'h55667788, 0, 0, 0);
        tbl1[4]  = mk(1, 32'hAABBCC,   1, 0, 0,  1, 32'h99AABBCC, 0, 0, 0);
        tbl1[5]  = mk(0, 32'h0,        1, 0, 0,  0, 32'h99AABBCC, 0, 0, 0);
        // flush with idle edge cycle; held vSync must not retrigger
        tbl1[6]  = mk(1, 32'h112233,   0, 0, 0,  0, 32'h99AABBCC, 0, 0, 0);
        tbl1[7]  = mk(0, 32'h0,        1, 0, 0,  1, 32'h11223300, 0, 0, 0);
        tbl1[8]  = mk(0, 32'h0,        1, 0, 0,  0, 32'h11223300, 0, 0, 0);
        tbl1[9]  = mk(1, 32'h010203,   1, 0, 0,  0, 32'h11223300, 0, 0, 0);
        tbl1[10] = mk(1, 32'h112233,   0, 0, 0,  1, 32'h01020311, 1, 0, 0);
        // flush with simultaneous pixel
        tbl1[11] = mk(1, 32'h445566,   1, 0, 0,  1, 32'h22330000, 0, 0, 0);
        tbl1[12] = mk(1, 32'h778899,   1, 0, 0,  1, 32'h44556677, 1, 0, 0);
        tbl1[13] = mk(0, 32'h0,        0, 1, 0,  0, 32'h44556677, 0, 0, 0);
        tbl1[14] = mk(0, 32'h0,        1, 0, 0,  1, 32'h88990000, 0, 0, 0);
        // overflow on word 1 of the default sequence
        tbl1[15] = mk(0, 32'h0,        0, 0, 0,  0, 32'h88990000, 0, 0, 0);
        tbl1[16] = mk(0, 32'h0,        1, 0, 0,  0, 32'h88990000, 0, 0, 0);
        tbl1[17] = mk(1, 32'h112233,   1, 0, 0,  0, 32'h88990000, 0, 0, 0);
        tbl1[18] = mk(1, 32'h445566,   1, 0, 1,  0, 32'h88990000, 0, 1, 1);
        tbl1[19] = mk(1, 32'h778899,   1, 0, 0,  1, 32'h55667788, 0, 1, 1);
        tbl1[20] = mk(1, 32'hAABBCC,   1, 0, 0,  1, 32'h99AABBCC, 0, 1, 1);
        // dropped flush word; data word after it still carries the first-word marker
        tbl1[21] = mk(1, 32'h112233,   1, 0, 0,  0, 32'h99AABBCC, 0, 1, 1);
        tbl1[22] = mk(0, 32'h0,        0, 0, 0,  0, 32'h99AABBCC, 0, 1, 1);
        tbl1[23] = mk(0, 32'h0,        1, 0, 1,  0, 32'h99AABBCC, 0, 1, 2);
        tbl1[24] = mk(1, 32'h445566,   1, 0, 0,  0, 32'h99AABBCC, 0, 1, 2);
        tbl1[25] = mk(1, 32'h778899,   1, 0, 0,  1, 32'h44556677, 1, 1, 2);

        // 16 -> 24 with hSync realign; no flush when empty
        tbl2[0]  = mk(0, 32'h0,        0, 1, 0,  0, 32'h0,        0, 0, 0);
        tbl2[1]  = mk(1, 32'hAAAA,     0, 1, 0,  0, 32'h0,        0, 0, 0);
        tbl2[2]  = mk(1, 32'hBBBB,     0, 1, 0,  1, 32'hAAAABB,   1, 0, 0);
        tbl2[3]  = mk(1, 32'hCCCC,     0, 1, 0,  1, 32'hBBCCCC,   0, 0, 0);
        tbl2[4]  = mk(0, 32'h0,        0, 0, 0,  0, 32'hBBCCCC,   0, 0, 0);
        tbl2[5]  = mk(0, 32'h0,        0, 1, 0,  0, 32'hBBCCCC,   0, 0, 0);

        rst = 1'b1;
        d1 = '0; v1 = 0; hs1 = 0; vs1 = 0; full1 = 0;
        d2 = '0; v2 = 0; hs2 = 0; vs2 = 0; full2 = 0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)  run2(i);
        for (int i = 0; i < 26; i++) run1(i);

        // reset pulse mid-word, asserted between clock edges
        @(negedge clk);
        d1 = 24'h112233; v1 = 1; vs1 = 0; full1 = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midword reset");
        @(negedge clk);
        v1 = 0;
        @(posedge clk);
        #1 chk_all_zero("reset held");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run1(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
